// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy (scoreboard) tracking.
// Two combinational read ports with optional write-to-read forwarding,
// one write port that also retires a pending reservation, and an
// issue-stage reservation port. Register 0 reads as zero and is never busy.
module regfile_scoreboard #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int BYPASS = 1,
  localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ok,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic            wr_fire;
  logic            rsv_fire;
  logic            fwd_ok;

  // Address 0 and addresses beyond the file are treated as hardwired zero.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  // Qualified strobes; forwarding is suppressed while reset is held so
  // the read ports show zero regardless of wr_en.
  always_comb begin
    wr_fire  = wr_en && addr_valid(wr_addr);
    rsv_fire = rsv_en && !flush && addr_valid(rsv_addr);
    fwd_ok   = (BYPASS != 0) && rst_n && wr_fire;
  end

  // Next data state: a qualified write updates its register, even during flush.
  always_comb begin
    regs_d = regs_q;
    if (wr_fire) regs_d[wr_addr] = wr_data;
  end

  // Next busy state: flush clears all; otherwise write clears, reservation sets
  // (reservation applied last so it wins on a same-register collision).
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_fire)  busy_d[wr_addr]  = 1'b0;
      if (rsv_fire) busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset clears all data and aborts every reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port A with optional forwarding of the in-flight write.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (addr_valid(rs1_addr)) begin
      if (fwd_ok && (wr_addr == rs1_addr)) begin
        rs1_data = wr_data;
      end else begin
        rs1_data = regs_q[rs1_addr];
        rs1_busy = busy_q[rs1_addr];
      end
    end
  end

  // Read port B with optional forwarding of the in-flight write.
  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (addr_valid(rs2_addr)) begin
      if (fwd_ok && (wr_addr == rs2_addr)) begin
        rs2_data = wr_data;
      end else begin
        rs2_data = regs_q[rs2_addr];
        rs2_busy = busy_q[rs2_addr];
      end
    end
  end

  // Reservation availability from registered busy state only.
  always_comb begin
    rsv_ok = 1'b1;
    if (addr_valid(rsv_addr)) rsv_ok = ~busy_q[rsv_addr];
  end

  // Population count of the registered busy vector.
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NREGS; i++) busy_cnt = busy_cnt + {{AW{1'b0}}, busy_q[i]};
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus pushes expectations,
// a monitor process pops and compares them whenever a sample is presented.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, rsv_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_en, rsv_en, flush;
  logic [XLEN-1:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic            rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
  logic            rsv_ok, nb_rsv_ok;
  logic [AW:0]     busy_cnt, nb_busy_cnt;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok),
    .flush(flush), .busy_cnt(nb_busy_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_RS1D = 0, S_RS1B = 1, S_RS2D = 2, S_RS2B = 3,
                 S_OK = 4, S_CNT = 5, S_NB_RS1D = 6, S_NB_RS1B = 7, S_NB_CNT = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_RS1D:    return rs1_data;
      S_RS1B:    return {31'd0, rs1_busy};
      S_RS2D:    return rs2_data;
      S_RS2B:    return {31'd0, rs2_busy};
      S_OK:      return {31'd0, rsv_ok};
      S_CNT:     return {26'd0, busy_cnt};
      S_NB_RS1D: return nb_rs1_data;
      S_NB_RS1B: return {31'd0, nb_rs1_busy};
      S_NB_CNT:  return {26'd0, nb_busy_cnt};
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: on every presented sample, drain and compare queued expectations.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = pick(e.sel);
        n_vec++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic present();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst_n = 1'b0; idle();
    rs1_addr = '0; rs2_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    #1;
    expect_val("reset rs1_data", S_RS1D, 32'h0);
    expect_val("reset rs1_busy", S_RS1B, 32'h0);
    expect_val("reset rsv_ok",   S_OK,   32'h1);
    expect_val("reset busy_cnt", S_CNT,  32'h0);
    present();
    @(negedge clk); rst_n = 1'b1;

    // Write then read back on the next cycle
    step(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step(); rs1_addr = 5'd5;
    expect_val("rd5 data", S_RS1D, 32'hDEADBEEF);
    expect_val("rd5 busy", S_RS1B, 32'h0);
    present();

    // Writes to register 0 are discarded
    step(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs2_addr = 5'd0;
    expect_val("r0 same cycle",  S_RS2D, 32'h0);
    expect_val("r0 cnt same",    S_CNT,  32'h0);
    present();
    step();
    expect_val("r0 next cycle",  S_RS2D, 32'h0);
    expect_val("r0 busy",        S_RS2B, 32'h0);
    expect_val("r0 cnt next",    S_CNT,  32'h0);
    present();

    // Forwarding versus stored value
    step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
    step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22; rs1_addr = 5'd7;
    expect_val("fwd bypass1",    S_RS1D,    32'h22);
    expect_val("fwd bypass0",    S_NB_RS1D, 32'h11);
    present();
    step();
    expect_val("r7 after bp1",   S_RS1D,    32'h22);
    expect_val("r7 after bp0",   S_NB_RS1D, 32'h22);
    present();

    // Reservations, retirement, collision
    step(); rsv_en = 1'b1; rsv_addr = 5'd3;
    step(); rsv_en = 1'b1; rsv_addr = 5'd9;
    step(); rsv_addr = 5'd3; rs1_addr = 5'd9;
    expect_val("cnt after 3,9",  S_CNT,  32'd2);
    expect_val("rsv_ok 3 busy",  S_OK,   32'h0);
    expect_val("rs1_busy 9",     S_RS1B, 32'h1);
    present();
    step(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    step(); rsv_addr = 5'd3;
    expect_val("cnt after wr3",  S_CNT, 32'd1);
    expect_val("rsv_ok 3 free",  S_OK,  32'h1);
    present();
    step(); rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    rs1_addr = 5'd9;
    expect_val("bp1 busy fwd",   S_RS1B,    32'h0);
    expect_val("bp0 busy stored",S_NB_RS1B, 32'h1);
    present();
    step();
    expect_val("cnt collision",  S_CNT,  32'd1);
    expect_val("r9 still busy",  S_RS1B, 32'h1);
    expect_val("r9 data written",S_RS1D, 32'h99);
    present();
    // WAW re-reservation keeps the bit and count
    step(); rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    expect_val("cnt waw",        S_CNT, 32'd1);
    present();

    // Flush beats a concurrent reservation
    step(); rsv_en = 1'b1; rsv_addr = 5'd3;
    step(); rsv_en = 1'b1; rsv_addr = 5'd4;
    step(); rsv_en = 1'b1; rsv_addr = 5'd5;
    step();
    expect_val("cnt pre flush",  S_CNT, 32'd4);
    present();
    step(); flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd6;
    step(); rs1_addr = 5'd6;
    expect_val("cnt post flush", S_CNT,    32'd0);
    expect_val("r6 busy flush",  S_RS1B,   32'h0);
    expect_val("rsv_ok 6",       S_OK,     32'h1);
    expect_val("nb cnt flush",   S_NB_CNT, 32'd0);
    present();
    // Reservation of register 0 is ignored
    step(); rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    expect_val("cnt rsv r0",     S_CNT, 32'd0);
    expect_val("rsv_ok r0",      S_OK,  32'h1);
    present();

    // Asynchronous reset mid-operation
    step(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
    step(); rsv_en = 1'b1; rsv_addr = 5'd2;
    step(); rs1_addr = 5'd2; rsv_addr = 5'd2;
    expect_val("r2 data",        S_RS1D, 32'h55);
    expect_val("cnt r2 busy",    S_CNT,  32'd1);
    expect_val("rsv_ok r2 busy", S_OK,   32'h0);
    present();
    #1; rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77; rsv_en = 1'b1;
    expect_val("rst async data", S_RS1D, 32'h0);
    expect_val("rst async busy", S_RS1B, 32'h0);
    expect_val("rst async cnt",  S_CNT,  32'd0);
    expect_val("rst async ok",   S_OK,   32'h1);
    present();
    @(posedge clk); #1;
    expect_val("rst held data",  S_RS1D, 32'h0);
    expect_val("rst held cnt",   S_CNT,  32'd0);
    present();
    @(negedge clk); idle(); rst_n = 1'b1;
    step();
    expect_val("post rst data",  S_RS1D, 32'h0);
    expect_val("post rst cnt",   S_CNT,  32'd0);
    expect_val("post rst ok",    S_OK,   32'h1);
    present();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

endmodule
